// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one prescaled period counter.
//
// Each channel double-buffers its high-time request. pwm_update loads a
// pending value; the pending value becomes active only at a period boundary,
// so a waveform is never cut mid-period.
//
// Parameters:
//   NUM_CH  number of independent channels (1..16)
//   WIDTH   ratio / counter width in bits (4..16)
//
// Ports:
//   clock         single clock, rising edge
//   reset_n       asynchronous active-low reset
//   clk_div       prescaler; the counter advances every clk_div+1 clocks
//   pwm_enable    per-channel output enable
//   pwm_ratio     packed high-time requests, channel i at [i*WIDTH +: WIDTH]
//   pwm_update    per-channel load request for pwm_ratio
//   pwm_done      one-clock pulse when a requested ratio becomes active
//   pwm_signal    registered PWM outputs
//   period_start  one-clock pulse at every period boundary
//
// Build option:
//   PWM_CENTER_ALIGN_EN  when defined, the counter runs up 0..MAX then down
//                        to 0 (center-aligned); otherwise edge-aligned only.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              clk_div,
  input  logic [NUM_CH-1:0]       pwm_enable,
  input  logic [NUM_CH*WIDTH-1:0] pwm_ratio,
  input  logic [NUM_CH-1:0]       pwm_update,
  output logic [NUM_CH-1:0]       pwm_done,
  output logic [NUM_CH-1:0]       pwm_signal,
  output logic                    period_start
);

  // MAX = 2^WIDTH-2, so a ratio of 2^WIDTH-1 exceeds every count (always high).
  localparam logic [WIDTH-1:0] MAX = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [7:0]       presc;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic             boundary;

  // '>=' rather than '==' so that lowering clk_div below the current
  // prescaler count still produces a tick on the next compare instead of
  // running the prescaler all the way round.
  assign tick = (presc >= clk_div);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic down;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (tick) begin
      if (!down) begin
        if (cnt == MAX) begin
          down <= 1'b1;
          cnt  <= MAX - ONE;
        end else begin
          cnt <= cnt + ONE;
        end
      end else begin
        if (cnt == ONE) begin
          down <= 1'b0;
          cnt  <= '0;
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  // Boundary is the tick that brings the down-count to 0.
  assign boundary = tick & down & (cnt == ONE);
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == MAX) ? '0 : cnt + ONE;
    end
  end

  assign boundary = tick & (cnt == MAX);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] act_q;
    logic             flag_q;
    logic             done_q;
    logic             sig_q;
    logic             apply;

    // An update landing on the boundary clock holds the whole request back
    // to the next boundary, so the channel still sees exactly one done pulse.
    assign apply = boundary & flag_q & ~pwm_update[i];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pend_q <= '0;
        act_q  <= '0;
        flag_q <= 1'b0;
        done_q <= 1'b0;
        sig_q  <= 1'b0;
      end else begin
        done_q <= apply;
        if (pwm_update[i]) begin
          pend_q <= pwm_ratio[i*WIDTH +: WIDTH];
          flag_q <= 1'b1;
        end else if (apply) begin
          flag_q <= 1'b0;
        end
        if (apply) begin
          act_q <= pend_q;
        end
        sig_q <= pwm_enable[i] & (cnt < act_q);
      end
    end

    assign pwm_done[i]   = done_q;
    assign pwm_signal[i] = sig_q;
  end

endmodule
